// File: rtl/cls_pkg.sv
// Shared definitions for the classification result stage.
// Holds the FSM state encoding, the default parameter values and the
// stream-length counter width helper, which other stream checkers also use.
package cls_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } cls_state_t;

    localparam int CLS_DW        = 16;
    localparam int CLS_NUM_CLASS = 10;
    localparam int CLS_IDX_W     = 4;

    // Counter width able to reach n+1 (saturation value) with one spare bit.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1) + 1;
    endfunction

endpackage

// File: rtl/cls_argmax_if.sv
// Score-in / result-out bus for cls_argmax.
//   blob_din_*  : serial signed score stream, one class per beat, eop-terminated
//   cls_dout_*  : registered result word (index, score, length error) + handshake
// slave  = the argmax stage, master = the producer/consumer side.
interface cls_argmax_if
    import cls_pkg::*;
#(
    parameter int DW    = CLS_DW,
    parameter int IDX_W = CLS_IDX_W
);
    logic                 blob_din_rdy;
    logic                 blob_din_en;
    logic                 blob_din_eop;
    logic signed [DW-1:0] blob_din;

    logic                 cls_dout_rdy;
    logic                 cls_dout_en;
    logic [IDX_W-1:0]     cls_dout_index;
    logic signed [DW-1:0] cls_dout_score;
    logic                 cls_dout_err;

    modport slave (
        output blob_din_rdy,
        input  blob_din_en, blob_din_eop, blob_din,
        input  cls_dout_rdy,
        output cls_dout_en, cls_dout_index, cls_dout_score, cls_dout_err
    );

    modport master (
        input  blob_din_rdy,
        output blob_din_en, blob_din_eop, blob_din,
        output cls_dout_rdy,
        input  cls_dout_en, cls_dout_index, cls_dout_score, cls_dout_err
    );
endinterface

// File: rtl/cls_max_cmp.sv
// Running maximum tracker.
//   load    : first beat of a frame, unconditionally becomes max at index 0
//   upd     : later beat eligible for comparison
//   din     : signed score, din_idx its class index
//   max_nxt / idx_nxt : values including the current beat (used to capture
//                       the final result on the eop beat without a bubble)
module cls_max_cmp #(
    parameter int DW    = 16,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 upd,
    input  logic signed [DW-1:0] din,
    input  logic [IDX_W-1:0]     din_idx,
    output logic signed [DW-1:0] max_nxt,
    output logic [IDX_W-1:0]     idx_nxt
);
    logic signed [DW-1:0] max_q;
    logic [IDX_W-1:0]     idx_q;

    // Strictly greater: ties keep the earlier (lower) index.
    always_comb begin
        max_nxt = max_q;
        idx_nxt = idx_q;
        if (load) begin
            max_nxt = din;
            idx_nxt = '0;
        end else if (upd && (din > max_q)) begin
            max_nxt = din;
            idx_nxt = din_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_nxt;
            idx_q <= idx_nxt;
        end
    end
endmodule

// File: rtl/cls_argmax.sv
// Classification result stage: argmax over a serial class-score stream.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : cls_argmax_if.slave (score stream in, result word out)
// One result per eop-terminated frame; the input is stalled while a result
// waits for the consumer. err flags frames whose beat count != NUM_CLASS.
module cls_argmax
    import cls_pkg::*;
#(
    parameter int DW        = CLS_DW,
    parameter int NUM_CLASS = CLS_NUM_CLASS,
    parameter int IDX_W     = CLS_IDX_W
) (
    input  logic         clk,
    input  logic         rst,
    cls_argmax_if.slave  bus
);
    localparam int CW = cnt_width(NUM_CLASS);

    cls_state_t           state_q, state_d;
    logic                 rdy_q;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                 accept, load, upd, fin;
    logic signed [DW-1:0] max_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic [IDX_W-1:0]     index_q;
    logic signed [DW-1:0] score_q;
    logic                 err_q;

    // rdy_q keeps ready low during reset and for the edge that releases it.
    assign bus.blob_din_rdy   = rdy_q && (state_q != HOLD);
    assign accept             = bus.blob_din_en && bus.blob_din_rdy;
    assign bus.cls_dout_en    = (state_q == HOLD);
    assign bus.cls_dout_index = index_q;
    assign bus.cls_dout_score = score_q;
    assign bus.cls_dout_err   = err_q;

    // Saturating at NUM_CLASS+1 keeps overlong frames distinguishable.
    assign cnt_inc = (cnt_q == CW'(NUM_CLASS + 1)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        upd     = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                load    = 1'b1;
                cnt_d   = CW'(1);
                fin     = bus.blob_din_eop;
                state_d = bus.blob_din_eop ? HOLD : ACC;
            end
            ACC: if (accept) begin
                // Beats past NUM_CLASS are counted but never compared.
                upd   = (cnt_q < CW'(NUM_CLASS));
                cnt_d = cnt_inc;
                if (bus.blob_din_eop) begin
                    fin     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: if (bus.cls_dout_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers keep their value after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= '0;
            score_q <= '0;
            err_q   <= 1'b0;
        end else if (fin) begin
            index_q <= idx_nxt;
            score_q <= max_nxt;
            err_q   <= (cnt_d != CW'(NUM_CLASS));
        end
    end

    cls_max_cmp #(.DW(DW), .IDX_W(IDX_W)) u_max (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .upd     (upd),
        .din     (bus.blob_din),
        .din_idx (IDX_W'(cnt_q)),
        .max_nxt (max_nxt),
        .idx_nxt (idx_nxt)
    );
endmodule

// File: tb/tb_cls_argmax.sv
module tb_cls_argmax;
    localparam int DW = 16;
    localparam int NC = 10;
    localparam int IW = 4;

    typedef logic signed [DW-1:0] sc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cls_argmax_if #(.DW(DW), .IDX_W(IW)) bus ();

    cls_argmax #(.DW(DW), .NUM_CLASS(NC), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: argmax over the first NC beats, first occurrence wins;
    // err whenever the frame length differs from NC.
    task automatic model(input sc_t s[$], output int idx, output sc_t mx, output logic err);
        int n;
        n   = (s.size() < NC) ? s.size() : NC;
        idx = 0;
        mx  = s[0];
        for (int k = 1; k < n; k++)
            if (s[k] > mx) begin
                mx  = s[k];
                idx = k;
            end
        err = (s.size() != NC);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents beats back to back; returns #1 after the eop-accepting edge.
    // first_wait = edges until the first beat was taken.
    task automatic drive_frame(input sc_t s[$], output int first_wait, output bit ok);
        int  i;
        int  cyc;
        bit  acc;
        i = 0; cyc = 0; first_wait = 0; ok = 1'b1;
        while (i < s.size()) begin
            bus.blob_din_en  = 1'b1;
            bus.blob_din     = s[i];
            bus.blob_din_eop = (i == s.size() - 1);
            acc = bus.blob_din_rdy;
            step();
            cyc++;
            if (acc) begin
                if (i == 0) first_wait = cyc;
                i++;
            end
            if (cyc > 300) begin
                ok = 1'b0;
                break;
            end
        end
        bus.blob_din_en  = 1'b0;
        bus.blob_din_eop = 1'b0;
    endtask

    task automatic check_result(input string name, input sc_t s[$]);
        int   idx;
        sc_t  mx;
        logic err;
        model(s, idx, mx, err);
        checks++;
        if (bus.cls_dout_en !== 1'b1 || bus.cls_dout_index !== IW'(idx) ||
            bus.cls_dout_score !== mx || bus.cls_dout_err !== err) begin
            errors++;
            $display("FAIL %s: got en=%0b idx=%0d score=%0d err=%0b, want en=1 idx=%0d score=%0d err=%0b",
                     name, bus.cls_dout_en, bus.cls_dout_index, bus.cls_dout_score,
                     bus.cls_dout_err, idx, mx, err);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        check_bit("reset_rdy", bus.blob_din_rdy, 1'b0);
        check_bit("reset_en", bus.cls_dout_en, 1'b0);
        check_int("reset_index", int'(bus.cls_dout_index), 0);
        check_int("reset_score", int'(bus.cls_dout_score), 0);
        check_bit("reset_err", bus.cls_dout_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("rdy_before_first_edge", bus.blob_din_rdy, 1'b0);
        step();
        check_bit("rdy_after_release", bus.blob_din_rdy, 1'b1);
    endtask

    task automatic test_nominal();
        sc_t s[$];
        int  fw;
        bit  ok;
        s = '{5, -3, 17, 2, 0, 9, -100, 16, 1, 4};
        bus.cls_dout_rdy = 1'b1;
        drive_frame(s, fw, ok);
        check_bit("nominal_done", ok, 1'b1);
        check_int("nominal_first_wait", fw, 1);
        check_result("nominal", s);
        check_int("nominal_index_2", int'(bus.cls_dout_index), 2);
        check_bit("nominal_rdy_low", bus.blob_din_rdy, 1'b0);
        step();
        check_bit("nominal_en_pulse", bus.cls_dout_en, 1'b0);
        check_bit("nominal_rdy_back", bus.blob_din_rdy, 1'b1);
    endtask

    task automatic test_tie_negative();
        sc_t s[$];
        int  fw;
        bit  ok;
        s = '{-50, -9, -30, -7, -1000, -8, -32768, -20, -7, -11};
        drive_frame(s, fw, ok);
        check_result("tie_negative", s);
        check_int("tie_score_hex", int'(bus.cls_dout_score[15:0]), 16'hFFF9);
        step();
    endtask

    task automatic test_backpressure();
        sc_t s[$];
        int  fw;
        bit  ok;
        sc_t sc0;
        s = '{1, 2, 3, 40, 5, 6, 7, 8, 9, 10};
        bus.cls_dout_rdy = 1'b0;
        drive_frame(s, fw, ok);
        check_result("bp_result", s);
        sc0 = bus.cls_dout_score;
        bus.blob_din_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.blob_din = sc_t'($urandom_range(0, 30000));
            step();
            check_bit("bp_rdy_low", bus.blob_din_rdy, 1'b0);
            check_result("bp_hold", s);
            check_int("bp_score_stable", int'(bus.cls_dout_score), int'(sc0));
        end
        bus.blob_din_en  = 1'b0;
        bus.cls_dout_rdy = 1'b1;
        step();
        check_bit("bp_en_drop", bus.cls_dout_en, 1'b0);
        check_bit("bp_rdy_return", bus.blob_din_rdy, 1'b1);
        check_int("bp_data_kept", int'(bus.cls_dout_score), int'(sc0));
    endtask

    task automatic test_length_error();
        sc_t s[$];
        int  fw;
        bit  ok;
        bus.cls_dout_rdy = 1'b1;
        s = '{3, -4, 12, 8, 11, -2, 0};
        drive_frame(s, fw, ok);
        check_result("short_frame", s);
        step();
        s = '{3, -4, 12, 8, 11, -2, 0, 1, 2, 5, 30000, 6};
        drive_frame(s, fw, ok);
        check_result("long_frame", s);
        check_int("long_ignored", int'(bus.cls_dout_score), 12);
        step();
    endtask

    task automatic test_back_to_back();
        sc_t a[$];
        sc_t b[$];
        int  fw;
        bit  ok;
        bus.cls_dout_rdy = 1'b1;
        a = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 100};
        b = '{-1, 77, 77, -5, 0, 3, 2, 1, 0, -9};
        drive_frame(a, fw, ok);
        check_result("b2b_first", a);
        drive_frame(b, fw, ok);
        check_int("b2b_gap", fw, 2);
        check_result("b2b_second", b);
        step();
    endtask

    task automatic test_async_reset();
        sc_t s[$];
        int  fw;
        bit  ok;
        for (int k = 0; k < 4; k++) begin
            bus.blob_din_en  = 1'b1;
            bus.blob_din     = sc_t'(1000 + k);
            bus.blob_din_eop = 1'b0;
            step();
        end
        bus.blob_din_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_bit("arst_rdy", bus.blob_din_rdy, 1'b0);
        check_bit("arst_en", bus.cls_dout_en, 1'b0);
        check_int("arst_score", int'(bus.cls_dout_score), 0);
        check_int("arst_index", int'(bus.cls_dout_index), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_bit("arst_no_result", bus.cls_dout_en, 1'b0);
        s = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 10};
        drive_frame(s, fw, ok);
        check_result("arst_next_frame", s);
        step();
    endtask

    task automatic test_random();
        sc_t s[$];
        int  fw;
        bit  ok;
        int  n;
        int  d;
        for (int f = 0; f < 25; f++) begin
            s.delete();
            n = $urandom_range(1, 13);
            for (int k = 0; k < n; k++)
                s.push_back((f % 2 == 0) ? sc_t'($urandom_range(0, 16) - 8)
                                         : sc_t'($urandom));
            d = $urandom_range(0, 3);
            bus.cls_dout_rdy = (d == 0);
            drive_frame(s, fw, ok);
            check_bit("rand_done", ok, 1'b1);
            check_result("rand_frame", s);
            for (int c = 0; c < d; c++) begin
                step();
                check_result("rand_hold", s);
            end
            bus.cls_dout_rdy = 1'b1;
            step();
            check_bit("rand_en_drop", bus.cls_dout_en, 1'b0);
        end
    endtask

    initial begin
        bus.blob_din_en  = 1'b0;
        bus.blob_din_eop = 1'b0;
        bus.blob_din     = '0;
        bus.cls_dout_rdy = 1'b0;
        test_reset();
        test_nominal();
        test_tie_negative();
        test_backpressure();
        test_length_error();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
